// File: rtl/clk_div_ratio_ctrl_pkg.sv
// Shared definitions for the divider ratio control stage:
// FSM encoding, UART prescale table and default ratio.
package clk_div_ratio_ctrl_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GATE   = 2'd1;
    localparam logic [1:0] ST_LOAD   = 2'd2;
    localparam logic [1:0] ST_SETTLE = 2'd3;

    localparam int PRESCALE_32 = 32;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_4  = 4;

    localparam int RATIO_P32 = 1;
    localparam int RATIO_P16 = 2;
    localparam int RATIO_P8  = 4;
    localparam int RATIO_P4  = 8;

    localparam int DEFAULT_RATIO_C = 1;

endpackage

// File: rtl/clk_div_ratio_ctrl_prescale_to_ratio.sv
// UART prescale to divider ratio translation.
// Shared with the TX-side control; unknown prescales flag invalid.
module prescale_to_ratio
    import clk_div_ratio_ctrl_pkg::*;
#(
    parameter int W = 6
) (
    input  logic [W-1:0] prescale,
    output logic [W-1:0] ratio,
    output logic         valid
);

    always_comb begin
        ratio = '0;
        valid = 1'b0;
        unique case (1'b1)
            (prescale == W'(PRESCALE_32)): begin
                ratio = W'(RATIO_P32);
                valid = 1'b1;
            end
            (prescale == W'(PRESCALE_16)): begin
                ratio = W'(RATIO_P16);
                valid = 1'b1;
            end
            (prescale == W'(PRESCALE_8)): begin
                ratio = W'(RATIO_P8);
                valid = 1'b1;
            end
            (prescale == W'(PRESCALE_4)): begin
                ratio = W'(RATIO_P4);
                valid = 1'b1;
            end
            default: begin
                ratio = '0;
                valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/clk_div_ratio_ctrl.sv
// Ratio-change control ahead of the integer clock divider.
// Gates the divider enable around every ratio load.
module clk_div_ratio_ctrl
    import clk_div_ratio_ctrl_pkg::*;
#(
    parameter int RATIO_WIDTH   = 6,
    parameter int DEFAULT_RATIO = DEFAULT_RATIO_C,
    parameter int GATE_CYCLES   = 4,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                   i_ref_clk,
    input  logic                   i_rst,
    input  logic                   i_en,
    input  logic                   i_cfg_valid,
    output logic                   o_cfg_ready,
    input  logic                   i_cfg_mode,
    input  logic [RATIO_WIDTH-1:0] i_cfg_value,
    output logic [RATIO_WIDTH-1:0] o_div_ratio,
    output logic                   o_clk_en,
    output logic                   o_busy,
    output logic                   o_cfg_err,
    output logic                   o_update_done
);

    localparam int MAXC = (GATE_CYCLES > SETTLE_CYCLES) ?
                          GATE_CYCLES : SETTLE_CYCLES;
    localparam int CW = $clog2(MAXC + 1);

    localparam logic [CW-1:0] G_LAST = CW'(GATE_CYCLES - 1);
    localparam logic [CW-1:0] S_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [1:0]             state;
    logic [CW-1:0]          cnt;
    logic [RATIO_WIDTH-1:0] pending_ratio;

    logic [RATIO_WIDTH-1:0] p2r_ratio;
    logic                   p2r_valid;
    logic [RATIO_WIDTH-1:0] map_ratio;
    logic                   map_valid;
    logic                   accept;

    prescale_to_ratio #(
        .W(RATIO_WIDTH)
    ) u_p2r (
        .prescale(i_cfg_value),
        .ratio   (p2r_ratio),
        .valid   (p2r_valid)
    );

    always_comb begin
        map_ratio = i_cfg_mode ? p2r_ratio : i_cfg_value;
        map_valid = i_cfg_mode ? p2r_valid : 1'b1;
    end

    assign o_cfg_ready = (state == ST_IDLE) & ~i_rst;
    assign accept      = i_cfg_valid & o_cfg_ready;

    always_ff @(posedge i_ref_clk) begin
        if (i_rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            pending_ratio <= '0;
            o_div_ratio   <= RATIO_WIDTH'(DEFAULT_RATIO);
            o_clk_en      <= 1'b0;
            o_busy        <= 1'b0;
            o_cfg_err     <= 1'b0;
            o_update_done <= 1'b0;
        end else begin
            o_cfg_err     <= 1'b0;
            o_update_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    o_clk_en <= i_en;
                    if (accept) begin
                        if (!map_valid) begin
                            o_cfg_err <= 1'b1;
                        end else if (map_ratio == o_div_ratio) begin
                            o_update_done <= 1'b1;
                        end else begin
                            pending_ratio <= map_ratio;
                            state         <= ST_GATE;
                            cnt           <= '0;
                            o_clk_en      <= 1'b0;
                            o_busy        <= 1'b1;
                        end
                    end
                end
                ST_GATE: begin
                    o_clk_en <= 1'b0;
                    if (cnt == G_LAST) begin
                        state <= ST_LOAD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_LOAD: begin
                    o_clk_en    <= 1'b0;
                    o_div_ratio <= pending_ratio;
                    state       <= ST_SETTLE;
                    cnt         <= '0;
                end
                ST_SETTLE: begin
                    // enable comes back via the IDLE follow one cycle later
                    o_clk_en <= 1'b0;
                    if (cnt == S_LAST) begin
                        state         <= ST_IDLE;
                        cnt           <= '0;
                        o_busy        <= 1'b0;
                        o_update_done <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    cnt      <= '0;
                    o_busy   <= 1'b0;
                    o_clk_en <= 1'b0;
                end
            endcase
        end
    end

endmodule
